// File: rtl/decodificador_teclado_if.sv
// Keypad bus: column sense, row drive and the debounced key-event outputs.
// The decoder uses the master modport; the keypad/consumer side uses slave.
interface decodificador_teclado_if;
    logic [3:0] col_matrix;
    logic [3:0] lin_matrix;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        input  col_matrix,
        output lin_matrix,
        output key_valid,
        output key_code
    );

    modport slave (
        output col_matrix,
        input  lin_matrix,
        input  key_valid,
        input  key_code
    );
endinterface

// File: rtl/decodificador_teclado.sv
// 4x4 matrix keypad scanner with press/release debounce and one pulse per key event.
// Optional feature macro AUTO_REPEAT_EN: re-pulses key_valid while a key stays held.
module decodificador_teclado #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_RATE     = 250
) (
    input  logic                          clk,
    input  logic                          rst,
    decodificador_teclado_if.master       kp
);

    typedef enum logic [1:0] {
        VARREDURA     = 2'd0,
        DEBOUNCE      = 2'd1,
        ESPERA_SOLTAR = 2'd2
    } state_t;

    localparam logic [15:0] DEB_TARGET = 16'(DEBOUNCE_CYCLES);

    // Row:column -> code, indexed by {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
            REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
            REPEAT_RATE < 1 || REPEAT_RATE > 65535) begin : g_bad_param
            $error("decodificador_teclado: parameter out of range");
        end
    endgenerate

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_row;
    logic [1:0]  w_row_next;
    logic [1:0]  r_slot;
    logic [1:0]  w_slot_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [3:0]  r_pat;
    logic [3:0]  w_pat_next;
    logic [3:0]  r_key_code;
    logic [3:0]  w_key_code_next;
    logic        r_key_valid;
    logic        w_key_valid_next;

    logic [3:0]  w_cols;
    logic [3:0]  w_low;
    logic        w_single_low;
    logic [1:0]  w_col_idx;
    logic [15:0] w_cnt_inc;

    // Columns are asynchronous to clk; nothing looks at them before two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= kp.col_matrix;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cols       = r_sync2;
    assign w_low        = ~w_cols;
    assign w_single_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_cnt_inc    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_comb begin
        w_col_idx = 2'd0;
        case (r_pat)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_drive
            assign kp.lin_matrix[gi] = (r_row != 2'(gi));
        end
    endgenerate

    assign kp.key_valid = r_key_valid;
    assign kp.key_code  = r_key_code;

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] REP_DELAY = 16'(REPEAT_DELAY);
    localparam logic [15:0] REP_RATE  = 16'(REPEAT_RATE);

    logic [15:0] r_rep_cnt;
    logic [15:0] w_rep_cnt_next;
    logic        r_rep_first;
    logic        w_rep_first_next;
    logic [15:0] w_rep_inc;
    logic [15:0] w_rep_target;

    assign w_rep_inc    = (r_rep_cnt == 16'hFFFF) ? r_rep_cnt : r_rep_cnt + 16'd1;
    assign w_rep_target = r_rep_first ? REP_DELAY : REP_RATE;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_row_next       = r_row;
        w_slot_next      = r_slot;
        w_cnt_next       = r_cnt;
        w_pat_next       = r_pat;
        w_key_code_next  = r_key_code;
        w_key_valid_next = 1'b0;
`ifdef AUTO_REPEAT_EN
        w_rep_cnt_next   = r_rep_cnt;
        w_rep_first_next = r_rep_first;
`endif
        case (r_state)
            VARREDURA: begin
                if (r_slot == 2'd3) begin
                    w_slot_next = 2'd0;
                    if (w_single_low) begin
                        w_pat_next   = w_cols;
                        w_cnt_next   = 16'd1;
                        w_state_next = DEBOUNCE;
                    end else begin
                        w_row_next = r_row + 2'd1;
                    end
                end else begin
                    w_slot_next = r_slot + 2'd1;
                end
            end
            DEBOUNCE: begin
                if (w_cols != r_pat) begin
                    w_state_next = VARREDURA;
                    w_row_next   = 2'd0;
                    w_slot_next  = 2'd0;
                    w_cnt_next   = 16'd0;
                end else if (w_cnt_inc >= DEB_TARGET) begin
                    w_key_code_next  = KEY_MAP[{r_row, w_col_idx}];
                    w_key_valid_next = 1'b1;
                    w_cnt_next       = 16'd0;
                    w_state_next     = ESPERA_SOLTAR;
`ifdef AUTO_REPEAT_EN
                    w_rep_cnt_next   = 16'd0;
                    w_rep_first_next = 1'b1;
`endif
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ESPERA_SOLTAR: begin
                // Release counter only advances on all-high columns; any low bit restarts it.
                if (w_cols == 4'b1111) begin
                    if (w_cnt_inc >= DEB_TARGET) begin
                        w_state_next = VARREDURA;
                        w_row_next   = 2'd0;
                        w_slot_next  = 2'd0;
                        w_cnt_next   = 16'd0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else begin
                    w_cnt_next = 16'd0;
                end
`ifdef AUTO_REPEAT_EN
                if (w_cols == r_pat) begin
                    if (w_rep_inc >= w_rep_target && !r_key_valid) begin
                        w_key_valid_next = 1'b1;
                        w_rep_cnt_next   = 16'd0;
                        w_rep_first_next = 1'b0;
                    end else begin
                        w_rep_cnt_next = w_rep_inc;
                    end
                end
`endif
            end
            default: begin
                w_state_next = VARREDURA;
                w_row_next   = 2'd0;
                w_slot_next  = 2'd0;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= VARREDURA;
            r_row       <= 2'd0;
            r_slot      <= 2'd0;
            r_cnt       <= 16'd0;
            r_pat       <= 4'b1111;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_slot      <= w_slot_next;
            r_cnt       <= w_cnt_next;
            r_pat       <= w_pat_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= 16'd0;
            r_rep_first <= 1'b1;
        end else begin
            r_rep_cnt   <= w_rep_cnt_next;
            r_rep_first <= w_rep_first_next;
        end
    end
`endif

endmodule

// File: doc/decodificador_teclado.md
DECODIFICADOR_TECLADO -- requirements
Module: decodificador_teclado

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50, consecutive stable cycles required for press and release (1 kHz clk gives 50 ms); legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_DELAY, default 1000, cycles from first key_valid to the first repeat; used only when AUTO_REPEAT_EN is defined.
REQ-003 SHALL have parameter REPEAT_RATE, default 250, cycles between subsequent repeats; used only when AUTO_REPEAT_EN is defined.
REQ-004 SHALL have port clk, input, 1, system clock (1 kHz), all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port col_matrix, input, 4, keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-007 SHALL have port lin_matrix, output, 4, keypad row drive, active-low, exactly one bit low at all times.
REQ-008 SHALL have port key_valid, output, 1, single-cycle pulse marking a debounced key event.
REQ-009 SHALL have port key_code, output, 4, code of the last key event, stable until the next event.

Function
REQ-010 SHALL pass col_matrix through a 2-FF synchronizer; all decisions use the synchronized value colS.
REQ-011 SHALL use FSM states VARREDURA, DEBOUNCE, ESPERA_SOLTAR.
REQ-012 In VARREDURA, SHALL drive rows 0,1,2,3,0... with each row held 4 cycles (lin_matrix 1110,1101,1011,0111) and sample colS in the 4th cycle of each slot.
REQ-013 At a sample, if exactly one colS bit is low, SHALL latch row/column, keep that row driven, load cnt=1, and enter DEBOUNCE. Otherwise, including zero or multiple low bits, SHALL continue scanning.
REQ-014 In DEBOUNCE, each cycle colS equals the latched pattern SHALL increment cnt. Any mismatch SHALL return to VARREDURA at row 0 with no pulse.
REQ-015 When cnt reaches DEBOUNCE_CYCLES, SHALL register key_code, assert key_valid for the next cycle only, and enter ESPERA_SOLTAR.
REQ-016 SHALL use this mapping as row:col -> code. Row0: 1,2,3,A. Row1: 4,5,6,B. Row2: 7,8,9,C. Row3: E(*),0,F(#),D. '#' SHALL yield 4'hF, the confirm code.
REQ-017 In ESPERA_SOLTAR, SHALL keep the latched row driven and count consecutive cycles with colS==4'b1111. On reaching DEBOUNCE_CYCLES, SHALL return to VARREDURA at row 0. Any low bit SHALL clear the release count.
REQ-018 SHALL emit no key_valid for a second key pressed while the first is held, or for any new press before the release is debounced.
REQ-019 SHALL use counters of 16 bits with saturation only, never wrap.
REQ-020 key_valid SHALL never be high in two consecutive cycles.

Reset
REQ-021 On rst high at a clk edge, SHALL set state VARREDURA, row 0 with lin_matrix=4'b1110, key_valid=0, key_code=4'h0, all counters 0, and synchronizer FFs to 4'b1111.
REQ-022 rst asserted mid-DEBOUNCE or mid-ESPERA_SOLTAR SHALL abort with no pulse. A key still held after reset SHALL be re-detected and reported once.

Configuration
REQ-023 With macro AUTO_REPEAT_EN defined, while a key stays held in ESPERA_SOLTAR, SHALL re-pulse key_valid with the same key_code REPEAT_DELAY cycles after the first pulse, then every REPEAT_RATE cycles until release.
REQ-024 Without AUTO_REPEAT_EN, SHALL emit exactly one key_valid per press regardless of hold duration, and SHALL not synthesize repeat logic.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-025 Hold row2/col1 low from row-2 sample for 10 cycles -> one key_valid pulse, key_code=4'h8, 4 cycles after detection.
REQ-026 Press row3/col2, release, then wait -> key_code=4'hF with one pulse. After 4 high cycles the FSM is back in VARREDURA with lin_matrix=1110.
REQ-027 Bounce row0/col0 low 2 cycles, high 1, low 2 -> no pulse. A later stable press -> exactly one pulse with code 4'h1.
REQ-028 Hold row1/col3 for 40 cycles -> without macro, 1 pulse with code 4'hB. With AUTO_REPEAT_EN, pulses at t0, t0+20, t0+25, t0+30, t0+35.
REQ-029 Assert rst 1 cycle during DEBOUNCE -> no pulse, outputs at reset values next cycle, and the held key is reported once afterwards.
REQ-030 Two columns low in the same row -> no detection, scan continues, and key_valid stays 0.
